// File: rtl/clock_uart_pkg.sv
// Shared types and constants for the clock-to-UART time reporter.
package clock_uart_pkg;

   // Reporter FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND      = 3'd1,
      PULSE     = 3'd2,
      WAIT_LOW  = 3'd3,
      WAIT_HIGH = 3'd4
   } state_e;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   localparam int unsigned MSG_LEN_CRLF = 10;
   localparam int unsigned MSG_LEN_BARE = 8;

endpackage

// File: rtl/uart_time_reporter_if.sv
// Byte handshake between the time reporter and uart_tx.
interface uart_time_reporter_if;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_ready;

   modport master (output tx_data, output tx_send, input tx_ready);
   modport slave  (input tx_data, input tx_send, output tx_ready);
endinterface

// File: rtl/bcd_digit_to_ascii.sv
// Converts one BCD nibble to its ASCII digit; non-decimal nibbles become '?'.
module bcd_digit_to_ascii
   import clock_uart_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // Decimal digits offset from '0', anything else flagged as '?'
   always_comb begin
      ascii = ASCII_QMARK;
      if (nibble <= 4'd9) begin
         ascii = ASCII_ZERO + {4'h0, nibble};
      end
   end

endmodule

// File: rtl/uart_time_reporter.sv
// Sends a snapshot of HH:MM:SS (optionally CR LF) to uart_tx, one byte per handshake.
module uart_time_reporter
   import clock_uart_pkg::*;
#(
   parameter bit         ADD_CRLF = 1'b1,
   parameter logic [7:0] SEP_CHAR = 8'h3A
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [7:0]                  hours_bcd,
   input  logic [7:0]                  minutes_bcd,
   input  logic [7:0]                  seconds_bcd,
   uart_time_reporter_if.master        tx,
   output logic                        busy,
   output logic                        done
);

   localparam logic [3:0] LAST_IDX = ADD_CRLF ? 4'(MSG_LEN_CRLF - 1) : 4'(MSG_LEN_BARE - 1);

   state_e     state_q;
   logic [3:0] idx_q;
   logic [7:0] snap_h_q, snap_m_q, snap_s_q;
   logic [7:0] tx_data_q;
   logic       tx_send_q;
   logic       busy_q;
   logic       done_q;

   logic [3:0] sel_idx;
   logic [7:0] src_h, src_m, src_s;
   logic [3:0] sel_nibble;
   logic [7:0] sel_ascii;
   logic [7:0] next_byte;

   // Byte to load next: byte 0 from live inputs when starting, else idx+1 from the snapshot
   always_comb begin
      sel_idx    = (state_q == IDLE) ? 4'd0 : idx_q + 4'd1;
      src_h      = (state_q == IDLE) ? hours_bcd   : snap_h_q;
      src_m      = (state_q == IDLE) ? minutes_bcd : snap_m_q;
      src_s      = (state_q == IDLE) ? seconds_bcd : snap_s_q;
      sel_nibble = 4'h0;
      case (sel_idx)
         4'd0:    sel_nibble = src_h[7:4];
         4'd1:    sel_nibble = src_h[3:0];
         4'd3:    sel_nibble = src_m[7:4];
         4'd4:    sel_nibble = src_m[3:0];
         4'd6:    sel_nibble = src_s[7:4];
         4'd7:    sel_nibble = src_s[3:0];
         default: sel_nibble = 4'h0;
      endcase
      next_byte = 8'h00;
      case (sel_idx)
         4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7: next_byte = sel_ascii;
         4'd2, 4'd5:                         next_byte = SEP_CHAR;
         4'd8:                               next_byte = ASCII_CR;
         4'd9:                               next_byte = ASCII_LF;
         default:                            next_byte = 8'h00;
      endcase
   end

   bcd_digit_to_ascii u_conv (
      .nibble (sel_nibble),
      .ascii  (sel_ascii)
   );

   // Handshake FSM; tx_data only moves when entering SEND so it is stable per byte
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= 4'd0;
         snap_h_q  <= 8'h00;
         snap_m_q  <= 8'h00;
         snap_s_q  <= 8'h00;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // a start coinciding with the done pulse is dropped
               if (start && !done_q) begin
                  snap_h_q  <= hours_bcd;
                  snap_m_q  <= minutes_bcd;
                  snap_s_q  <= seconds_bcd;
                  idx_q     <= 4'd0;
                  tx_data_q <= next_byte;
                  busy_q    <= 1'b1;
                  state_q   <= SEND;
               end
            end
            SEND: begin
               if (tx.tx_ready) begin
                  tx_send_q <= 1'b1;
                  state_q   <= PULSE;
               end
            end
            PULSE: begin
               tx_send_q <= 1'b0;
               state_q   <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!tx.tx_ready) begin
                  state_q <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (tx.tx_ready) begin
                  if (idx_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     idx_q     <= idx_q + 4'd1;
                     tx_data_q <= next_byte;
                     state_q   <= SEND;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx.tx_data = tx_data_q;
   assign tx.tx_send = tx_send_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Self-checking bench: two reporters (with and without CR LF) against a line-level model.
module tb_uart_time_reporter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       start;
   logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
   logic       hold;
   logic       rand_period;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_line[10];
   int         base[2];
   int         d0, d1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dig(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
   endfunction

   task automatic build(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      exp_line[0] = dig(h[7:4]);
      exp_line[1] = dig(h[3:0]);
      exp_line[2] = 8'h3A;
      exp_line[3] = dig(m[7:4]);
      exp_line[4] = dig(m[3:0]);
      exp_line[5] = 8'h3A;
      exp_line[6] = dig(s[7:4]);
      exp_line[7] = dig(s[3:0]);
      exp_line[8] = 8'h0D;
      exp_line[9] = 8'h0A;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int Len = (g == 0) ? 10 : 8;
      uart_time_reporter_if ifc ();
      logic busy, done;

      uart_time_reporter #(
         .ADD_CRLF (g == 0),
         .SEP_CHAR (8'h3A)
      ) dut (
         .clk         (clk),
         .reset_n     (reset_n),
         .start       (start),
         .hours_bcd   (hours_bcd),
         .minutes_bcd (minutes_bcd),
         .seconds_bcd (seconds_bcd),
         .tx          (ifc),
         .busy        (busy),
         .done        (done)
      );

      // uart_tx stand-in: latches on send, drops ready for a while, then raises it
      logic rdy = 1'b1;
      int   cnt = 0;
      always @(posedge clk) begin
         if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) rdy <= 1'b1;
         end else if (ifc.tx_send) begin
            rdy <= 1'b0;
            cnt <= rand_period ? int'($urandom_range(1, 40)) : 40;
         end
      end
      assign ifc.tx_ready = rdy & ~hold;

      int         nbytes = 0;
      int         ndone  = 0;
      int         idx;
      logic [7:0] cap[10];
      logic       prev_send = 1'b0;
      logic       in_hs = 1'b0;
      logic [7:0] hs_data;

      // Per-cycle compare against the expected line
      always @(negedge clk) begin
         if (reset_n) begin
            idx = nbytes - base[g];
            if (ifc.tx_send) begin
               check("busy_during_send", busy, 1);
               check("send_one_cycle", prev_send, 0);
               check("byte_in_range", idx < Len, 1);
               if (idx >= 0 && idx < Len) begin
                  check("byte_value", ifc.tx_data, exp_line[idx]);
                  cap[idx] = ifc.tx_data;
               end
               nbytes++;
               in_hs   = 1'b1;
               hs_data = ifc.tx_data;
            end else if (in_hs) begin
               check("data_stable", ifc.tx_data, hs_data);
               if (ifc.tx_ready) in_hs = 1'b0;
            end
            if (done) begin
               check("bytes_at_done", idx, Len);
               check("busy_low_at_done", busy, 0);
               ndone++;
            end
            prev_send = ifc.tx_send;
         end else begin
            in_hs     = 1'b0;
            prev_send = 1'b0;
         end
      end
   end

   task automatic start_line(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      hours_bcd   = h;
      minutes_bcd = m;
      seconds_bcd = s;
      build(h, m, s);
      base[0] = g_dut[0].nbytes;
      base[1] = g_dut[1].nbytes;
      d0      = g_dut[0].ndone;
      d1      = g_dut[1].ndone;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start0", g_dut[0].busy, 1);
      check("busy_after_start1", g_dut[1].busy, 1);
      check("byte0_after_start0", g_dut[0].ifc.tx_data, exp_line[0]);
      check("byte0_after_start1", g_dut[1].ifc.tx_data, exp_line[0]);
   endtask

   task automatic wait_lines();
      int n = 0;
      while ((g_dut[0].ndone <= d0 || g_dut[1].ndone <= d1) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("line0_finished", g_dut[0].ndone - d0, 1);
      check("line1_finished", g_dut[1].ndone - d1, 1);
      check("line0_bytes", g_dut[0].nbytes - base[0], 10);
      check("line1_bytes", g_dut[1].nbytes - base[1], 8);
   endtask

   task automatic idle_check(input int cycles);
      int n0 = g_dut[0].nbytes;
      int n1 = g_dut[1].nbytes;
      repeat (cycles) @(negedge clk);
      check("no_extra_line0", g_dut[0].nbytes, n0);
      check("no_extra_line1", g_dut[1].nbytes, n1);
      check("idle_busy0", g_dut[0].busy, 0);
      check("idle_busy1", g_dut[1].busy, 0);
   endtask

   logic [7:0] lit_crlf[10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                                8'h0D, 8'h0A};
   logic [7:0] lit_bare[8]  = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39};
   logic [7:0] lit_snap[10] = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33,
                                8'h0D, 8'h0A};

   function automatic logic [7:0] rand_bcd();
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
      return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
   endfunction

   initial begin
      int n;
      reset_n     = 1'b0;
      start       = 1'b0;
      hold        = 1'b0;
      rand_period = 1'b0;
      hours_bcd   = 8'h00;
      minutes_bcd = 8'h00;
      seconds_bcd = 8'h00;
      base[0]     = 0;
      base[1]     = 0;
      build(8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("reset_tx_data", (g == 0) ? g_dut[0].ifc.tx_data : g_dut[1].ifc.tx_data, 0);
      end
      check("reset_tx_send", g_dut[0].ifc.tx_send | g_dut[1].ifc.tx_send, 0);
      check("reset_busy", g_dut[0].busy | g_dut[1].busy, 0);
      check("reset_done", g_dut[0].done | g_dut[1].done, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic line with send timing, plus a start during the bare instance's done pulse
      start_line(8'h12, 8'h34, 8'h56);
      @(posedge clk); #1;
      check("send_high_n1", g_dut[0].ifc.tx_send, 1);
      @(posedge clk); #1;
      check("send_low_n2", g_dut[0].ifc.tx_send, 0);
      n = 0;
      while (!g_dut[1].done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("bare_done_seen", g_dut[1].done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_lines();
      for (int i = 0; i < 10; i++) check("lit_crlf", g_dut[0].cap[i], lit_crlf[i]);
      idle_check(100);

      // Bare terminator case
      start_line(8'h23, 8'h59, 8'h59);
      wait_lines();
      for (int i = 0; i < 8; i++) check("lit_bare", g_dut[1].cap[i], lit_bare[i]);

      // Snapshot: inputs change and start re-pulses mid-line
      start_line(8'h01, 8'h02, 8'h03);
      n = 0;
      while (g_dut[0].nbytes - base[0] < 2 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      hours_bcd   = 8'h09;
      minutes_bcd = 8'h09;
      seconds_bcd = 8'h09;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_lines();
      for (int i = 0; i < 10; i++) check("lit_snap", g_dut[0].cap[i], lit_snap[i]);
      idle_check(200);

      // Invalid BCD nibble
      start_line(8'hA5, 8'h00, 8'h07);
      wait_lines();
      check("qmark_byte0", g_dut[0].cap[0], 8'h3F);
      check("qmark_byte1", g_dut[0].cap[1], 8'h35);

      // Backpressure: ready held low after start
      hold = 1'b1;
      start_line(8'h17, 8'h45, 8'h00);
      repeat (20) begin
         @(negedge clk);
         check("send_held_low", g_dut[0].ifc.tx_send | g_dut[1].ifc.tx_send, 0);
      end
      hold = 1'b0;
      n = 0;
      while (!g_dut[0].ifc.tx_send && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_first_send", g_dut[0].ifc.tx_send, 1);
      check("bp_first_byte", g_dut[0].ifc.tx_data, 8'h31);
      wait_lines();

      // Reset mid-line
      start_line(8'h12, 8'h34, 8'h56);
      n = 0;
      while (g_dut[0].nbytes - base[0] < 4 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("rst_tx_data", g_dut[0].ifc.tx_data | g_dut[1].ifc.tx_data, 0);
      check("rst_tx_send", g_dut[0].ifc.tx_send | g_dut[1].ifc.tx_send, 0);
      check("rst_busy", g_dut[0].busy | g_dut[1].busy, 0);
      check("rst_done", g_dut[0].done | g_dut[1].done, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start_line(8'h12, 8'h34, 8'h56);
      wait_lines();
      for (int i = 0; i < 10; i++) check("post_rst_line", g_dut[0].cap[i], lit_crlf[i]);

      // Randomised lines with random uart busy time and mid-line disturbances
      rand_period = 1'b1;
      for (int k = 0; k < 12; k++) begin
         start_line(rand_bcd(), rand_bcd(), rand_bcd());
         n = $urandom_range(0, 150);
         repeat (n) @(negedge clk);
         if (g_dut[0].busy && g_dut[1].busy && (g_dut[0].nbytes - base[0]) < 6 &&
             (g_dut[1].nbytes - base[1]) < 6) begin
            hours_bcd   = rand_bcd();
            minutes_bcd = rand_bcd();
            seconds_bcd = rand_bcd();
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_lines();
      end
      idle_check(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
